// File: rtl/vsync_ctrl.sv
// Vertical sync/blanking controller: turns the vertical counter's per-line strobes
// into sync/visible/blank flags, frame pulses, a frame counter and a sticky order-error flag.
module vsync_ctrl #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b0,
  parameter int FRAME_W           = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               pixEn,
  input  logic               hCountEnd,
  output logic               vCountIncr,
  input  logic               vCountZero,
  input  logic               vVisEnd,
  input  logic               vBeginPulse,
  input  logic               vEndPulse,
  input  logic               vEndActive,
  input  logic               vCountEnd,
  output logic               vsync,
  output logic               vVisible,
  output logic               vBlank,
  output logic               frameStart,
  output logic               vblankIrq,
  output logic [FRAME_W-1:0] frameCount,
  input  logic               clrErr,
  output logic               seqErr
);

  typedef enum logic [2:0] {S_IDLE, S_VIS, S_VFP, S_VSYNC, S_VBP} state_t;

  // strobe bit order: {vCountEnd, vEndActive, vEndPulse, vBeginPulse, vVisEnd, vCountZero}
  logic [5:0]         strb, rise, hist_q, hist_d;
  state_t             state_q, state_d, tgt, walk;
  logic               jump, legal, reached, err;
  logic               frame_start_q, frame_start_d;
  logic               irq_q, irq_d;
  logic               seq_err_q, seq_err_d;
  logic [FRAME_W-1:0] fc_q, fc_d;

  function automatic state_t next_legal(input state_t s);
    case (s)
      S_VIS:   return S_VFP;
      S_VFP:   return S_VSYNC;
      S_VSYNC: return S_VBP;
      S_VBP:   return S_VIS;
      default: return S_IDLE;
    endcase
  endfunction

  // the strobe whose rise legally enters state s
  function automatic logic entry_rise(input state_t s, input logic [5:0] r);
    case (s)
      S_VIS:   return r[0];
      S_VFP:   return r[1];
      S_VSYNC: return r[2];
      S_VBP:   return r[3];
      default: return 1'b0;
    endcase
  endfunction

  assign vCountIncr = pixEn & hCountEnd & nrst;

  always_comb begin
    strb          = {vCountEnd, vEndActive, vEndPulse, vBeginPulse, vVisEnd, vCountZero};
    rise          = strb & ~hist_q;
    hist_d        = strb;
    state_d       = state_q;
    tgt           = state_q;
    walk          = state_q;
    jump          = 1'b0;
    legal         = 1'b1;
    reached       = 1'b0;
    err           = 1'b0;
    frame_start_d = 1'b0;
    irq_d         = 1'b0;
    fc_d          = fc_q;

    if (state_q == S_IDLE) begin
      if (rise[0]) begin
        state_d       = S_VIS;
        frame_start_d = 1'b1;
      end
    end else begin
      if      (rise[0]) begin tgt = S_VIS;   jump = 1'b1; end
      else if (rise[3]) begin tgt = S_VBP;   jump = 1'b1; end
      else if (rise[2]) begin tgt = S_VSYNC; jump = 1'b1; end
      else if (rise[1]) begin tgt = S_VFP;   jump = 1'b1; end

      if (jump) begin
        // a multi-state jump is legal only if every skipped state's strobe rose too
        walk = next_legal(state_q);
        for (int i = 0; i < 4; i++) begin
          if (!reached) begin
            if (walk == tgt) reached = 1'b1;
            else begin
              legal = legal & entry_rise(walk, rise);
              walk  = next_legal(walk);
            end
          end
        end
        state_d = tgt;
        if (!legal) err = 1'b1;
        if (tgt == S_VIS) begin
          frame_start_d = 1'b1;
          fc_d          = fc_q + 1'b1;
        end
      end

      if (rise[4]) irq_d = 1'b1;
      if (rise[5] && state_q != S_VBP) err = 1'b1;
    end

    seq_err_d = err | (seq_err_q & ~clrErr);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      hist_q        <= '0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
      seq_err_q     <= 1'b0;
      fc_q          <= '0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      frame_start_q <= frame_start_d;
      irq_q         <= irq_d;
      seq_err_q     <= seq_err_d;
      fc_q          <= fc_d;
    end
  end

  assign vsync      = (state_q == S_VSYNC) ? VSYNC_ACTIVE_HIGH : ~VSYNC_ACTIVE_HIGH;
  assign vVisible   = (state_q == S_VIS);
  assign vBlank     = (state_q == S_VFP) || (state_q == S_VSYNC) || (state_q == S_VBP);
  assign frameStart = frame_start_q;
  assign vblankIrq  = irq_q;
  assign frameCount = fc_q;
  assign seqErr     = seq_err_q;

endmodule

// File: doc/vsync_ctrl.md
Name: vsync_ctrl

Overview:
- Vertical sync/blanking controller; sits directly downstream of the vertical line counter and consumes its one-hot-per-line timing strobes.
- Generates the line-advance enable for that counter from the horizontal stage, and produces the vertical sync, visible and blanking flags.
- Also produces frame-level pulses and a frame counter for the pixel fetch and CPU-interface logic.
- Tracks the expected strobe order and flags timing-sequence violations.

Parameters:
- VSYNC_ACTIVE_HIGH, 0, vsync polarity: 0 = low during the sync pulse, 1 = high during the sync pulse.
- FRAME_W, 8, width of the frame counter.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- pixEn  in  1  horizontal count advance enable (one pixel step)
- hCountEnd  in  1  horizontal counter is at its last pixel of the line
- vCountIncr  out  1  line-advance enable to the vertical counter
- vCountZero  in  1  vertical count is at line 0 (first visible line)
- vVisEnd  in  1  vertical count is at the first non-visible line
- vBeginPulse  in  1  vertical count is at the first sync line
- vEndPulse  in  1  vertical count is at the first post-sync line
- vEndActive  in  1  vertical count is at the end-of-active-region line
- vCountEnd  in  1  vertical count is at the last line of the frame
- vsync  out  1  vertical sync, polarity per VSYNC_ACTIVE_HIGH
- vVisible  out  1  current line is visible
- vBlank  out  1  current line is blanked (front porch, sync or back porch)
- frameStart  out  1  one-cycle pulse at start of each frame
- vblankIrq  out  1  one-cycle pulse at end of the active region
- frameCount  out  FRAME_W  completed-frame counter, wraps
- clrErr  in  1  clears seqErr
- seqErr  out  1  sticky strobe-order violation flag

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- Reset values: state = IDLE; vsync = inactive level; vVisible, vBlank, frameStart, vblankIrq and seqErr = 0; frameCount = 0; all strobe history registers = 0.
- vCountIncr = pixEn & hCountEnd & nrst. It is combinational with zero latency.
- Edge detection:
  - Each strobe (vCountZero, vVisEnd, vBeginPulse, vEndPulse, vEndActive, vCountEnd) stays high for a whole line.
  - Each strobe has a history register; rise = strobe & ~history.
  - All state changes are driven by rises only.
  - Outputs change one clk after the counter changes.
- States and legal transitions:
  - IDLE -> VISIBLE on rise of vCountZero.
  - VISIBLE -> VFP on rise of vVisEnd.
  - VFP -> VSYNC on rise of vBeginPulse.
  - VSYNC -> VBP on rise of vEndPulse.
  - VBP -> VISIBLE on rise of vCountZero.
  - No rise: state holds.
- Entering VISIBLE (from IDLE or VBP): frameStart = 1 for exactly one cycle. frameCount increments modulo 2^FRAME_W, except when the predecessor is IDLE.
- Out-of-order rise:
  - Example: vBeginPulse rises while in VISIBLE.
  - Jump to that strobe's target state (resynchronise) and set seqErr.
  - A vCountZero rise from VISIBLE/VFP/VSYNC is also a violation; it still produces frameStart and a frameCount increment.
- Simultaneous rises (degenerate timing, e.g. zero front porch):
  - Priority is vCountZero > vEndPulse > vBeginPulse > vVisEnd.
  - Go to the highest-priority target.
  - seqErr is not set if the skipped states lie on the legal path from the current state.
- vEndActive rise: vblankIrq = 1 for one cycle, independent of state. A vEndActive rise in IDLE is ignored.
- vCountEnd rise: no state change. It sets seqErr if state != VBP.
- Output decode (from the state register, glitch-free):
  - vsync active iff state = VSYNC.
  - vVisible iff state = VISIBLE.
  - vBlank iff state in {VFP, VSYNC, VBP}.
- seqErr clear: clrErr clears seqErr on the next clk. A violation in the same cycle as clrErr wins (seqErr stays 1).
- Reset mid-frame: asynchronous return to reset values. With history cleared, a still-high vCountZero yields a rise on the first clk after release (frameStart, no frameCount increment); any other still-high strobe is ignored in IDLE.

Test Plan:
- Reset release with vCountZero=1 -> cycle 1: frameStart=1, vVisible=1, frameCount=0; vsync=1 (VSYNC_ACTIVE_HIGH=0).
- Legal frame, strobes at lines 0/480/490/492/524 with vEndActive at 480 -> VISIBLE, VFP, VSYNC (vsync=0), VBP in order; next vCountZero gives frameCount=1, seqErr=0; vblankIrq pulses exactly once.
- pixEn=1 with hCountEnd=1 -> vCountIncr=1 same cycle; pixEn=0 with hCountEnd=1 -> 0; nrst=0 -> 0.
- vBeginPulse raised while VISIBLE -> state VSYNC next cycle, seqErr=1; clrErr pulse -> seqErr=0; clrErr coincident with a violation -> seqErr stays 1.
- vVisEnd and vBeginPulse rise together from VISIBLE -> VSYNC, seqErr=0. frameCount at 255 (FRAME_W=8) plus vCountZero rise from VBP -> frameCount=0.
- nrst asserted during VSYNC -> vsync inactive immediately; after release with vCountZero=0 and vEndPulse=1 -> state stays IDLE, vBlank=0, seqErr=0.
